// File: rtl/req_burst_unpacker.sv
// req_burst_unpacker: buffers packed read/write requests from the arbiter,
// unpacks the header and expands read bursts into per-beat cache requests
// with FIXED / INCR / WRAP address generation. Writes pass through as
// single-beat requests. All req_* outputs come straight from flops.
module req_burst_unpacker #(
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 64,
    parameter  int ID_WIDTH   = 4,
    parameter  int DEPTH      = 8,
    localparam int HDR_WIDTH  = ADDR_WIDTH + ID_WIDTH + 13,
    localparam int STRB_WIDTH = DATA_WIDTH / 8,
    localparam int W_WIDTH    = HDR_WIDTH + DATA_WIDTH + STRB_WIDTH,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W_WIDTH-1:0]    in_data,
    input  logic                  in_valid,
    input  logic                  in_rw,
    output logic                  in_ready,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic                  req_rw,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [ID_WIDTH-1:0]   req_id,
    output logic [2:0]            req_size,
    output logic [DATA_WIDTH-1:0] req_data,
    output logic [STRB_WIDTH-1:0] req_strb,
    output logic                  req_last,
    output logic [CNT_W-1:0]      fifo_count
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

    localparam logic [CNT_W-1:0]      CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]      PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    // Next beat address for a burst; WRAP wraps inside a (len+1)<<size window.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [2:0]            size,
        input logic [1:0]            burst,
        input logic [7:0]            len
    );
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] wrap_mask;
        logic [ADDR_WIDTH-1:0] nxt;
        step      = ADDR_ONE << size;
        wrap_mask = ((({{(ADDR_WIDTH-8){1'b0}}, len}) + ADDR_ONE) << size) - ADDR_ONE;
        case (burst)
            2'b00:   nxt = addr;
            2'b10:   nxt = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
            default: nxt = addr + step;
        endcase
        return nxt;
    endfunction

    // FIFO storage and bookkeeping
    logic [W_WIDTH:0]        mem_q [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    push_s, pop_s, adv_s, drop_s;
    logic                    fifo_nempty_s, out_free_s, fire_s;

    // Output / burst state
    state_t                  state_q, state_d, load_state_s;
    logic [7:0]              beats_left_q, beats_left_d, load_beats_s;
    logic [7:0]              len_q, len_d;
    logic [1:0]              burst_q, burst_d;
    logic                    req_valid_q, req_valid_d, req_rw_q, req_rw_d;
    logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
    logic [ID_WIDTH-1:0]     req_id_q, req_id_d;
    logic [2:0]              req_size_q, req_size_d;
    logic [DATA_WIDTH-1:0]   req_data_q, req_data_d;
    logic [STRB_WIDTH-1:0]   req_strb_q, req_strb_d;
    logic                    req_last_q, req_last_d;

    // Head-of-FIFO packet fields
    logic [W_WIDTH:0]        head_s;
    logic                    head_rw_s;
    logic [7:0]              head_len_s;
    logic [2:0]              head_size_s;
    logic [1:0]              head_burst_s;
    logic [ID_WIDTH-1:0]     head_id_s;
    logic [ADDR_WIDTH-1:0]   head_addr_s;
    logic [STRB_WIDTH-1:0]   head_strb_s;
    logic [DATA_WIDTH-1:0]   head_data_s;

    assign head_s        = mem_q[rd_ptr_q];
    assign head_rw_s     = head_s[W_WIDTH];
    assign head_len_s    = head_s[7:0];
    assign head_size_s   = head_s[10:8];
    assign head_burst_s  = head_s[12:11];
    assign head_id_s     = head_s[13 +: ID_WIDTH];
    assign head_addr_s   = head_s[13 + ID_WIDTH +: ADDR_WIDTH];
    assign head_strb_s   = head_s[HDR_WIDTH +: STRB_WIDTH];
    assign head_data_s   = head_s[HDR_WIDTH + STRB_WIDTH +: DATA_WIDTH];

    assign load_beats_s  = head_rw_s ? 8'd0 : head_len_s;
    assign load_state_s  = (load_beats_s != 8'd0) ? ST_BURST : ST_IDLE;

    assign in_ready      = (count_q < CNT_FULL);
    assign push_s        = in_valid && in_ready;
    assign fifo_nempty_s = (count_q != CNT_ZERO);
    assign out_free_s    = !req_valid_q || req_ready;
    assign fire_s        = req_valid_q && req_ready;

    // Packet storage; contents need no reset since occupancy is tracked separately
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {in_rw, in_data};
        end
    end

    // FIFO pointer and occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) wr_ptr_d = wr_ptr_q + PTR_ONE;
        else        wr_ptr_d = wr_ptr_q;
        if (pop_s)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        else        rd_ptr_d = rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Next-state: pop a new packet, advance the burst, or drop req_valid
    always_comb begin
        state_d = state_q;
        pop_s   = 1'b0;
        adv_s   = 1'b0;
        drop_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fifo_nempty_s && out_free_s) begin
                    pop_s   = 1'b1;
                    state_d = load_state_s;
                end else if (out_free_s) begin
                    drop_s  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (fire_s && (beats_left_q != 8'd0)) begin
                    adv_s   = 1'b1;
                end else if (fire_s && fifo_nempty_s) begin
                    pop_s   = 1'b1;
                    state_d = load_state_s;
                end else if (fire_s) begin
                    drop_s  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BURST;
                end
            end
            default: begin
                drop_s  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output register next values: load beat 0, step address, or go idle
    always_comb begin
        req_valid_d  = req_valid_q;
        req_rw_d     = req_rw_q;
        req_addr_d   = req_addr_q;
        req_id_d     = req_id_q;
        req_size_d   = req_size_q;
        req_data_d   = req_data_q;
        req_strb_d   = req_strb_q;
        req_last_d   = req_last_q;
        beats_left_d = beats_left_q;
        len_d        = len_q;
        burst_d      = burst_q;
        if (pop_s) begin
            req_valid_d  = 1'b1;
            req_rw_d     = head_rw_s;
            req_addr_d   = head_addr_s;
            req_id_d     = head_id_s;
            req_size_d   = head_size_s;
            req_data_d   = head_rw_s ? head_data_s : {DATA_WIDTH{1'b0}};
            req_strb_d   = head_rw_s ? head_strb_s : {STRB_WIDTH{1'b0}};
            req_last_d   = (load_beats_s == 8'd0);
            beats_left_d = load_beats_s;
            len_d        = head_len_s;
            burst_d      = head_burst_s;
        end else if (adv_s) begin
            req_addr_d   = next_addr(req_addr_q, req_size_q, burst_q, len_q);
            beats_left_d = beats_left_q - 8'd1;
            req_last_d   = (beats_left_q == 8'd1);
        end else if (drop_s) begin
            req_valid_d  = 1'b0;
        end else begin
            req_valid_d  = req_valid_q;
        end
    end

    // State, FIFO and output registers; reset discards everything in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            count_q      <= CNT_ZERO;
            beats_left_q <= 8'd0;
            len_q        <= 8'd0;
            burst_q      <= 2'b00;
            req_valid_q  <= 1'b0;
            req_rw_q     <= 1'b0;
            req_addr_q   <= {ADDR_WIDTH{1'b0}};
            req_id_q     <= {ID_WIDTH{1'b0}};
            req_size_q   <= 3'd0;
            req_data_q   <= {DATA_WIDTH{1'b0}};
            req_strb_q   <= {STRB_WIDTH{1'b0}};
            req_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            beats_left_q <= beats_left_d;
            len_q        <= len_d;
            burst_q      <= burst_d;
            req_valid_q  <= req_valid_d;
            req_rw_q     <= req_rw_d;
            req_addr_q   <= req_addr_d;
            req_id_q     <= req_id_d;
            req_size_q   <= req_size_d;
            req_data_q   <= req_data_d;
            req_strb_q   <= req_strb_d;
            req_last_q   <= req_last_d;
        end
    end

    assign req_valid  = req_valid_q;
    assign req_rw     = req_rw_q;
    assign req_addr   = req_addr_q;
    assign req_id     = req_id_q;
    assign req_size   = req_size_q;
    assign req_data   = req_data_q;
    assign req_strb   = req_strb_q;
    assign req_last   = req_last_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_req_burst_unpacker.sv
// Self-checking bench for req_burst_unpacker: directed scenarios plus a
// randomized mix, checked against a packet-level expansion model.
module tb_req_burst_unpacker;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;
    localparam int SW = DW / 8;
    localparam int HW = AW + IW + 13;
    localparam int W  = HW + DW + SW;

    logic          clk;
    logic          rst;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_rw;
    logic          in_ready;
    logic          req_valid;
    logic          req_ready;
    logic          req_rw;
    logic [AW-1:0] req_addr;
    logic [IW-1:0] req_id;
    logic [2:0]    req_size;
    logic [DW-1:0] req_data;
    logic [SW-1:0] req_strb;
    logic          req_last;
    logic [3:0]    fifo_count;

    int checks   = 0;
    int failures = 0;

    // beat image: {15'b0, rw, addr[111:80], id[79:76], size[75:73], data[72:9], strb[8:1], last[0]}
    logic [127:0] exp_q[$];
    logic [127:0] got_q[$];

    req_burst_unpacker dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_rw(in_rw),
        .in_ready(in_ready), .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_id(req_id), .req_size(req_size), .req_data(req_data),
        .req_strb(req_strb), .req_last(req_last), .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] beat(input logic rw, input logic [31:0] a, input logic [3:0] id,
                                          input logic [2:0] sz, input logic [63:0] d,
                                          input logic [7:0] s, input logic last);
        return {15'd0, rw, a, id, sz, d, s, last};
    endfunction

    function automatic logic [127:0] obs_beat();
        return beat(req_rw, req_addr, req_id, req_size, req_data, req_strb, req_last);
    endfunction

    function automatic logic [W-1:0] make_pkt(input logic rw, input logic [7:0] len, input logic [2:0] sz,
                                              input logic [1:0] bst, input logic [3:0] id,
                                              input logic [31:0] a, input logic [7:0] s,
                                              input logic [63:0] d);
        logic [W-1:0] p;
        p = '0;
        p[7:0] = len; p[10:8] = sz; p[12:11] = bst; p[16:13] = id; p[48:17] = a;
        if (rw) begin
            p[56:49]  = s;
            p[120:57] = d;
        end
        return p;
    endfunction

    // Reference: expand an accepted packet into its full list of beats
    task automatic model_push(input logic rw, input logic [W-1:0] p);
        logic [7:0]  len;
        logic [2:0]  sz;
        logic [1:0]  bst;
        logic [31:0] a, step, wb, base, ai;
        len = p[7:0]; sz = p[10:8]; bst = p[12:11]; a = p[48:17];
        if (rw) begin
            exp_q.push_back(beat(1'b1, a, p[16:13], sz, p[120:57], p[56:49], 1'b1));
        end else begin
            step = 32'd1 << sz;
            wb   = (32'(len) + 32'd1) << sz;
            base = a & ~(wb - 32'd1);
            for (int i = 0; i <= int'(len); i++) begin
                if (bst == 2'b00)      ai = a;
                else if (bst == 2'b10) ai = base + ((a - base + 32'(i) * step) % wb);
                else                   ai = a + 32'(i) * step;
                exp_q.push_back(beat(1'b0, ai, p[16:13], sz, 64'd0, 8'd0, i == int'(len)));
            end
        end
    endtask

    // One clock: score handshakes seen now, advance, then check stall stability
    task automatic cycle();
        logic [127:0] snap;
        logic [127:0] e;
        bit in_fire, out_fire, stalled;
        in_fire  = in_valid && in_ready;
        out_fire = req_valid && req_ready;
        stalled  = req_valid && !req_ready;
        snap     = obs_beat();
        if (out_fire) begin
            got_q.push_back(snap);
            if (exp_q.size() == 0) begin
                check("unexpected_beat", snap, 128'd0);
            end else begin
                e = exp_q.pop_front();
                check("beat", snap, e);
            end
        end
        if (in_fire) model_push(in_rw, in_data);
        @(posedge clk);
        #1;
        if (stalled) check("stable", {req_valid, obs_beat()}, {1'b1, snap});
    endtask

    task automatic send(input logic rw, input logic [W-1:0] p);
        bit fired;
        int n;
        fired = 1'b0; n = 0;
        in_valid = 1'b1; in_rw = rw; in_data = p;
        while (!fired && n < 200) begin
            fired = in_ready;
            cycle();
            n++;
        end
        in_valid = 1'b0; in_rw = 1'b0; in_data = '0;
        check("send_timeout", 128'(fired), 128'd1);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || req_valid === 1'b1) && n < limit) begin
            cycle();
            n++;
        end
        check("drain_timeout", 128'(n < limit), 128'd1);
    endtask

    initial begin
        int sent;
        int total_beats;
        logic [1:0] bst;
        logic [7:0] len;
        logic       rw;

        rst = 1'b0; in_valid = 1'b0; in_data = '0; in_rw = 1'b0; req_ready = 1'b0;
        #3;
        check("rst_valid", 128'(req_valid), 128'd0);
        check("rst_outputs", obs_beat(), 128'd0);
        check("rst_count", 128'(fifo_count), 128'd0);
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 128'(in_ready), 128'd1);

        // 1: INCR read, 4 beats, latency 2
        req_ready = 1'b1; got_q.delete();
        send(1'b0, make_pkt(1'b0, 8'd3, 3'd3, 2'b01, 4'd5, 32'h1000, 8'd0, 64'd0));
        check("lat_t1", 128'(req_valid), 128'd0);
        cycle();
        check("lat_t2", 128'(req_valid), 128'd1);
        drain(100);
        check("t1_nbeats", 128'(got_q.size()), 128'd4);
        for (int i = 0; i < 4 && i < got_q.size(); i++)
            check("t1_beat", got_q[i], beat(1'b0, 32'h1000 + 32'(i) * 32'd8, 4'd5, 3'd3, 64'd0, 8'd0, i == 3));

        // 2: WRAP read then FIXED read
        got_q.delete();
        send(1'b0, make_pkt(1'b0, 8'd3, 3'd2, 2'b10, 4'd1, 32'h1034, 8'd0, 64'd0));
        send(1'b0, make_pkt(1'b0, 8'd2, 3'd3, 2'b00, 4'd2, 32'h0200, 8'd0, 64'd0));
        drain(100);
        check("t2_nbeats", 128'(got_q.size()), 128'd7);
        if (got_q.size() == 7) begin
            check("t2_wrap0", 128'(got_q[0][111:80]), 128'h1034);
            check("t2_wrap1", 128'(got_q[1][111:80]), 128'h1038);
            check("t2_wrap2", 128'(got_q[2][111:80]), 128'h103C);
            check("t2_wrap3", 128'(got_q[3][111:80]), 128'h1030);
            for (int i = 4; i < 7; i++)
                check("t2_fixed", got_q[i], beat(1'b0, 32'h200, 4'd2, 3'd3, 64'd0, 8'd0, i == 6));
        end

        // 3: single write beat
        got_q.delete();
        send(1'b1, make_pkt(1'b1, 8'd0, 3'd3, 2'b01, 4'd2, 32'h40, 8'hFF, 64'hDEADBEEF_CAFEF00D));
        drain(100);
        check("t3_nbeats", 128'(got_q.size()), 128'd1);
        if (got_q.size() == 1)
            check("t3_write", got_q[0], beat(1'b1, 32'h40, 4'd2, 3'd3, 64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b1));

        // 4: backpressure, FIFO fills to DEPTH, then drains in order
        req_ready = 1'b0; got_q.delete(); total_beats = 0;
        for (int k = 0; k < 9; k++) begin
            rw  = k[0];
            len = 8'($urandom_range(0, 2));
            send(rw, make_pkt(rw, len, 3'($urandom_range(0, 3)), 2'b01, 4'(k), 32'h8000 + 32'(k) * 32'h100,
                              8'($urandom), {$urandom, $urandom}));
            total_beats += rw ? 1 : int'(len) + 1;
        end
        check("t4_count_full", 128'(fifo_count), 128'd8);
        check("t4_in_ready", 128'(in_ready), 128'd0);
        in_valid = 1'b1; in_rw = 1'b0; in_data = make_pkt(1'b0, 8'd0, 3'd0, 2'b01, 4'hF, 32'hBAD0, 8'd0, 64'd0);
        repeat (3) cycle();
        in_valid = 1'b0; in_data = '0;
        check("t4_count_hold", 128'(fifo_count), 128'd8);
        req_ready = 1'b1;
        drain(300);
        check("t4_nbeats", 128'(got_q.size()), 128'(total_beats));
        check("t4_count_empty", 128'(fifo_count), 128'd0);

        // 5: read len 1 then write, no bubble
        got_q.delete();
        send(1'b0, make_pkt(1'b0, 8'd1, 3'd2, 2'b01, 4'd7, 32'h500, 8'd0, 64'd0));
        send(1'b1, make_pkt(1'b1, 8'd0, 3'd2, 2'b01, 4'd7, 32'h600, 8'h0F, 64'h1234));
        check("t5_v0", 128'(req_valid), 128'd1);
        cycle();
        check("t5_v1", 128'(req_valid), 128'd1);
        cycle();
        check("t5_v2", 128'({req_valid, req_rw}), 128'd3);
        cycle();
        check("t5_v3", 128'(req_valid), 128'd0);
        drain(50);

        // 6: reset in the middle of a len 7 burst
        got_q.delete();
        send(1'b0, make_pkt(1'b0, 8'd7, 3'd3, 2'b01, 4'd9, 32'h3000, 8'd0, 64'd0));
        send(1'b1, make_pkt(1'b1, 8'd0, 3'd3, 2'b01, 4'd1, 32'h3100, 8'h01, 64'h55));
        send(1'b1, make_pkt(1'b1, 8'd0, 3'd3, 2'b01, 4'd2, 32'h3200, 8'h02, 64'h66));
        repeat (2) cycle();
        check("t6_pre_count", 128'(fifo_count), 128'd2);
        check("t6_pre_valid", 128'(req_valid), 128'd1);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_valid", 128'(req_valid), 128'd0);
        check("t6_rst_outputs", obs_beat(), 128'd0);
        check("t6_rst_count", 128'(fifo_count), 128'd0);
        exp_q.delete(); got_q.delete();
        @(posedge clk); @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;
        check("t6_in_ready", 128'(in_ready), 128'd1);
        send(1'b0, make_pkt(1'b0, 8'd0, 3'd1, 2'b01, 4'd3, 32'h2468, 8'd0, 64'd0));
        drain(50);
        check("t6_nbeats", 128'(got_q.size()), 128'd1);
        if (got_q.size() == 1)
            check("t6_beat", got_q[0], beat(1'b0, 32'h2468, 4'd3, 3'd1, 64'd0, 8'd0, 1'b1));

        // 7: randomized traffic with random backpressure
        sent = 0;
        for (int c = 0; c < 4000 && sent < 60; c++) begin
            bit fired;
            if (!in_valid && $urandom_range(0, 1) == 1) begin
                rw  = 1'($urandom_range(0, 1));
                bst = 2'($urandom_range(0, 3));
                if (bst == 2'b10) len = 8'((2 << $urandom_range(0, 3)) - 1);
                else              len = 8'($urandom_range(0, 9));
                in_rw = rw;
                in_data = make_pkt(rw, len, 3'($urandom_range(0, 7)), bst, 4'($urandom), $urandom,
                                   8'($urandom), {$urandom, $urandom});
                in_valid = 1'b1;
            end
            req_ready = ($urandom_range(0, 3) != 0);
            fired = in_valid && in_ready;
            cycle();
            if (fired) begin
                sent++;
                in_valid = 1'b0;
                in_data  = '0;
            end
        end
        in_valid = 1'b0;
        check("t7_sent", 128'(sent), 128'd60);
        req_ready = 1'b1;
        drain(2000);
        check("t7_empty", 128'(exp_q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/req_burst_unpacker.md
Name: req_burst_unpacker

Overview:
- Sits directly downstream of the read/write round-robin arbiter and consumes its packed request stream (out_data / out_valid / read_or_write / out_ready).
- Buffers packed requests in a DEPTH-entry FIFO, unpacks the fields and expands each read burst into per-beat cache requests with AXI FIXED/INCR/WRAP address generation.
- Write packets carry one data beat each and pass through as single-beat requests.
- Feeds the cache controller over a valid/ready request interface.

Parameters:
- ADDR_WIDTH, 32, request address width
- DATA_WIDTH, 64, write data width; strobe width is DATA_WIDTH/8
- ID_WIDTH, 4, transaction ID width
- DEPTH, 8, FIFO entries; power of two, at least 2
- HDR_WIDTH (localparam), ADDR_WIDTH+ID_WIDTH+13, header bits
- W_WIDTH (localparam), HDR_WIDTH+DATA_WIDTH+DATA_WIDTH/8, packet width

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- in_data  in  W_WIDTH  packed request from the arbiter
- in_valid  in  1  packet valid
- in_rw  in  1  0 = read, 1 = write
- in_ready  out  1  FIFO can accept a packet
- req_valid  out  1  beat request valid
- req_ready  in  1  cache controller accepts the beat
- req_rw  out  1  0 = read, 1 = write
- req_addr  out  ADDR_WIDTH  beat address
- req_id  out  ID_WIDTH  transaction ID
- req_size  out  3  bytes per beat = 2^size
- req_data  out  DATA_WIDTH  write data; 0 for reads
- req_strb  out  DATA_WIDTH/8  write strobes; 0 for reads
- req_last  out  1  final beat of the burst
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Packet layout, LSB first:
  - len[7:0], size[10:8], burst[12:11], id, addr form the header in bits [HDR_WIDTH-1:0].
  - Write packets then carry strb, then data above the header.
  - Read packets are zero above HDR_WIDTH; those bits are ignored.
- Input handshake:
  - Push when in_valid && in_ready; {in_rw, in_data} is stored.
  - in_ready = (fifo_count < DEPTH) and depends only on registers.
  - When the FIFO is full, no push occurs, even in a cycle that pops.
  - Push and pop in the same cycle leave fifo_count unchanged.
- FSM states: IDLE, BURST.
  - In IDLE, if the FIFO is non-empty and the output is free (req_valid == 0, or req_valid && req_ready): pop the head and load the output registers with beat 0.
    - Address = header addr.
    - beats_left = len for reads, 0 for writes.
    - Go to BURST if beats_left != 0.
  - In BURST, on each req_valid && req_ready: advance the address, decrement beats_left, hold all other fields.
  - On the handshake of the beat with beats_left == 0, return to IDLE. The same-cycle pop of the next packet applies, so back-to-back bursts have no bubble.
- req_last = (beats_left == 0). Writes always have req_last = 1.
- Latency: an input handshake in cycle t into an empty FIFO with an idle output gives req_valid in cycle t+2.
- Output stability: while req_valid && !req_ready, all req_* outputs hold stable.
- Address generation, step = 1 << size:
  - FIXED (00): address unchanged.
  - INCR (01) and reserved (11): addr + step, modulo 2^ADDR_WIDTH.
  - WRAP (10): wrap_bytes = (len+1) << size; base = addr & ~(wrap_bytes-1); next = base | ((addr + step) & (wrap_bytes-1)).
  - WRAP len is 1, 3, 7 or 15; other values produce an undefined address and are not checked.
- Reset (asynchronous, any time including mid-burst):
  - FIFO is emptied; fifo_count = 0; in_ready = 1 once rst is released.
  - State = IDLE.
  - req_valid, req_rw, req_addr, req_id, req_size, req_data, req_strb, req_last all = 0.
  - Any partial burst is discarded.

Test Plan:
1. Single read, INCR, addr 0x1000, size 3, len 3, id 5, req_ready = 1 -> 4 beats with addr 0x1000, 0x1008, 0x1010, 0x1018; req_last only on the 4th beat; first req_valid 2 cycles after the push.
2. WRAP read, addr 0x1034, size 2, len 3 -> addr 0x1034, 0x1038, 0x103C, 0x1030. FIXED read, len 2 at 0x200 -> three beats at 0x200.
3. Write, data 0xDEADBEEF_CAFEF00D, strb 0xFF, addr 0x40 -> one beat with req_rw = 1, matching data and strb, req_last = 1.
4. req_ready = 0 with 9 packets offered -> fifo_count reaches 8, in_ready = 0, outputs held stable. Then release req_ready -> all packets emerge in order with no loss and no duplication.
5. Back-to-back read len 1 followed by a write, req_ready = 1 -> 3 consecutive req_valid cycles with no bubble.
6. Assert rst in the middle of a len 7 burst -> all outputs 0 and fifo_count = 0 immediately. After release, a new len 0 read emerges with the correct address.
